// File: rtl/fp_mult_pkg.sv
// Shared types and constants for the single-precision multiplier datapath.
// Used by the unpack helper and the sequential mantissa front stage.
package fp_mult_pkg;

  localparam int MANT_W = 24;
  localparam int EXP_W  = 8;
  localparam int XEXP_W = 10;
  localparam int BIAS   = 127;
  localparam int ACC_W  = 2 * MANT_W + 1;

  localparam logic [XEXP_W-1:0] NEG_BIAS_10 = 10'h381;
  localparam logic [EXP_W-1:0]  EXP_MAX     = 8'hFF;
  localparam logic [4:0]        MUL_LAST    = 5'd23;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } state_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
    logic              zero;
    logic              inf_nan;
  } unpacked_t;

endpackage

// File: rtl/adder_10bit.sv
// 10-bit modular adder for the extended exponent path.
// Carry-out is intentionally not produced; results wrap mod 1024.
module adder_10bit (
  input  logic [9:0] a,
  input  logic [9:0] b,
  output logic [9:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/adder_25bit.sv
// 25-bit modular adder used for the shift-add partial sum.
// The partial sum never exceeds 25 bits, so no carry-out is needed.
module adder_25bit (
  input  logic [24:0] a,
  input  logic [24:0] b,
  output logic [24:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/fp_unpack.sv
// Splits an IEEE754 single into sign, effective exponent and mantissa.
// Denormals use exponent 1 and a clear hidden bit.
module fp_unpack
  import fp_mult_pkg::*;
(
  input  logic [31:0] x,
  output unpacked_t   u
);

  logic hid;

  always_comb begin
    hid       = |x[30:23];
    u.sign    = x[31];
    u.exp     = hid ? x[30:23] : 8'd1;
    u.mant    = {hid, x[22:0]};
    u.zero    = ~hid & ~|x[22:0];
    u.inf_nan = (x[30:23] == EXP_MAX);
  end

endmodule

// File: rtl/fp_mult_mant_seq.sv
// Sequential front stage of the FP multiplier: sign, biased exponent
// and a one-bit-per-cycle shift-add 24x24 mantissa product.
module fp_mult_mant_seq
  import fp_mult_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        sign,
  output logic [9:0]  exp_x,
  output logic [47:0] prod,
  output logic        zero,
  output logic        inf_nan
);

  state_t state_q, state_d;

  unpacked_t ua, ub;

  logic [9:0]       exp_pair, exp_new;
  logic [ACC_W-1:0] acc_q;
  logic [23:0]      mcand_q;
  logic [24:0]      addend, hi_sum;
  logic [4:0]       count_q;

  logic       cap_sign, cap_inf;
  logic [9:0] cap_exp;

  logic accept, mul_last;
  logic zero_in, inf_in, sign_in;

  fp_unpack u_unpack_a (.x(a), .u(ua));
  fp_unpack u_unpack_b (.x(b), .u(ub));

  adder_10bit u_exp_sum (
    .a   ({2'b0, ua.exp}),
    .b   ({2'b0, ub.exp}),
    .sum (exp_pair)
  );

  adder_10bit u_exp_bias (
    .a   (exp_pair),
    .b   (NEG_BIAS_10),
    .sum (exp_new)
  );

  // Low half of the accumulator doubles as the multiplier shift register.
  assign addend = acc_q[0] ? {1'b0, mcand_q} : '0;

  adder_25bit u_psum (
    .a   (acc_q[48:24]),
    .b   (addend),
    .sum (hi_sum)
  );

  assign zero_in   = ua.zero | ub.zero;
  assign inf_in    = ua.inf_nan | ub.inf_nan;
  assign sign_in   = ua.sign ^ ub.sign;
  assign in_ready  = rst_n & (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid & in_ready;

  always_comb begin
    state_d  = state_q;
    mul_last = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = zero_in ? DONE : MUL;
      end
      MUL: begin
        if (count_q == MUL_LAST) begin
          mul_last = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      count_q  <= '0;
      cap_sign <= 1'b0;
      cap_exp  <= '0;
      cap_inf  <= 1'b0;
    end else if (accept) begin
      acc_q    <= {25'd0, ub.mant};
      mcand_q  <= ua.mant;
      count_q  <= '0;
      cap_sign <= sign_in;
      cap_exp  <= exp_new;
      cap_inf  <= inf_in;
    end else if (state_q == MUL) begin
      acc_q   <= {1'b0, hi_sum, acc_q[23:1]};
      count_q <= count_q + 5'd1;
    end
  end

  // Result registers change only when a result is completed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign    <= 1'b0;
      exp_x   <= '0;
      prod    <= '0;
      zero    <= 1'b0;
      inf_nan <= 1'b0;
    end else if (accept && zero_in) begin
      sign    <= sign_in;
      exp_x   <= exp_new;
      prod    <= '0;
      zero    <= 1'b1;
      inf_nan <= inf_in;
    end else if (mul_last) begin
      sign    <= cap_sign;
      exp_x   <= cap_exp;
      prod    <= {hi_sum, acc_q[23:1]};
      zero    <= 1'b0;
      inf_nan <= cap_inf;
    end
  end

endmodule

// File: tb/tb_fp_mult_mant_seq.sv
// Self-checking bench for fp_mult_mant_seq against a plain-arithmetic
// reference model, with directed, random, backpressure and reset cases.
module tb_fp_mult_mant_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        sign;
  logic [9:0]  exp_x;
  logic [47:0] prod;
  logic        zero;
  logic        inf_nan;

  logic [60:0] res;
  assign res = {sign, exp_x, prod, zero, inf_nan};

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fp_mult_mant_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (op_a),
    .b         (op_b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sign      (sign),
    .exp_x     (exp_x),
    .prod      (prod),
    .zero      (zero),
    .inf_nan   (inf_nan)
  );

  localparam logic [31:0] DA [6] = '{
    32'h40400000, 32'hBF800000, 32'h00000000,
    32'h00800000, 32'h7F7FFFFF, 32'h7F800000};
  localparam logic [31:0] DB [6] = '{
    32'h40000000, 32'h3F800000, 32'h40000000,
    32'h00800000, 32'h7F7FFFFF, 32'h3F800000};
  localparam logic [60:0] DEXP [6] = '{
    {1'b0, 10'h081, 48'h600000000000, 1'b0, 1'b0},
    {1'b1, 10'h07F, 48'h400000000000, 1'b0, 1'b0},
    {1'b0, 10'h002, 48'h000000000000, 1'b1, 1'b0},
    {1'b0, 10'h383, 48'h400000000000, 1'b0, 1'b0},
    {1'b0, 10'h17D, 48'hFFFFFE000001, 1'b0, 1'b0},
    {1'b0, 10'h0FF, 48'h400000000000, 1'b0, 1'b1}};

  // Reference: exponent and product from IEEE fields with plain integers.
  task automatic model(input logic [31:0] x, input logic [31:0] y,
                       output logic [60:0] exp_res, output int exp_lat);
    int ex, ey;
    longint unsigned mx, my, p;
    logic z, n, s;
    logic [9:0] e;
    ex = (x[30:23] == 8'd0) ? 1 : int'(x[30:23]);
    ey = (y[30:23] == 8'd0) ? 1 : int'(y[30:23]);
    mx = longint'(x[22:0]) + ((x[30:23] != 0) ? 64'd8388608 : 64'd0);
    my = longint'(y[22:0]) + ((y[30:23] != 0) ? 64'd8388608 : 64'd0);
    z = (mx == 0) || (my == 0);
    p = z ? 64'd0 : mx * my;
    n = (x[30:23] == 8'hFF) || (y[30:23] == 8'hFF);
    s = x[31] ^ y[31];
    e = 10'(ex + ey - 127);
    exp_res = {s, e, p[47:0], z, n};
    exp_lat = z ? 0 : 24;
  endtask

  // Drives one accept; lat = clock edges from accept to out_valid rising.
  task automatic do_op(input logic [31:0] x, input logic [31:0] y,
                       output int lat);
    int g;
    g = 0;
    @(negedge clk);
    while (!in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    op_a = x;
    op_b = y;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if ({in_ready, out_valid, res} !== 63'd0) begin
      bad++;
      $display("FAIL reset_state: got rdy=%b vld=%b res=%h want all 0",
               in_ready, out_valid, res);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: got rdy=%b vld=%b want rdy=1 vld=0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_directed();
    int lat, elat;
    logic [60:0] er;
    for (int i = 0; i < 6; i++) begin
      model(DA[i], DB[i], er, elat);
      do_op(DA[i], DB[i], lat);
      total++;
      if (lat !== elat) begin
        bad++;
        $display("FAIL dir_lat[%0d]: got %0d want %0d", i, lat, elat);
      end
      total++;
      if (res !== DEXP[i]) begin
        bad++;
        $display("FAIL dir_res[%0d]: got %h want %h", i, res, DEXP[i]);
      end
      total++;
      if (res !== er) begin
        bad++;
        $display("FAIL dir_model[%0d]: got %h want %h", i, res, er);
      end
      retire();
    end
  endtask

  task automatic test_random();
    int lat, elat;
    logic [60:0] er;
    logic [31:0] x, y;
    for (int i = 0; i < 40; i++) begin
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 5))
        0: x[30:23] = 8'd0;
        1: y[30:23] = 8'hFF;
        2: y = {y[31], 31'd0};
        3: begin x[30:23] = 8'd0; y[30:23] = 8'd0; end
        default: ;
      endcase
      model(x, y, er, elat);
      do_op(x, y, lat);
      total++;
      if (lat !== elat) begin
        bad++;
        $display("FAIL rnd_lat[%0d]: got %0d want %0d", i, lat, elat);
      end
      total++;
      if (res !== er) begin
        bad++;
        $display("FAIL rnd_res[%0d] a=%h b=%h: got %h want %h",
                 i, x, y, res, er);
      end
      retire();
    end
  endtask

  task automatic test_backpressure();
    int lat, elat;
    logic [60:0] er;
    model(32'h40400000, 32'h40000000, er, elat);
    do_op(32'h40400000, 32'h40000000, lat);
    for (int i = 0; i < 10; i++) begin
      op_a = $urandom;
      op_b = $urandom;
      in_valid = i[0];
      @(negedge clk);
      total++;
      if ({out_valid, in_ready, res} !== {1'b1, 1'b0, er}) begin
        bad++;
        $display("FAIL bp_hold[%0d]: got vld=%b rdy=%b res=%h want 1 0 %h",
                 i, out_valid, in_ready, res, er);
      end
    end
    in_valid = 1'b1;
    op_a = 32'h3F800000;
    op_b = 32'h3F800000;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release: got vld=%b rdy=%b want vld=0 rdy=1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int lat, elat;
    logic [60:0] er;
    logic [31:0] x, y;
    do_op(32'h40400000, 32'h3F800000, lat);
    for (int i = 0; i < 3; i++) begin
      x = $urandom;
      y = $urandom;
      x[30:23] = 8'd100 + 8'(i);
      op_a = x;
      op_b = y;
      in_valid = 1'b1;
      out_ready = 1'b1;
      model(x, y, er, elat);
      do_op(x, y, lat);
      out_ready = 1'b0;
      total++;
      if (lat !== elat || res !== er) begin
        bad++;
        $display("FAIL b2b[%0d]: got lat=%0d res=%h want lat=%0d res=%h",
                 i, lat, res, elat, er);
      end
    end
    retire();
  endtask

  task automatic test_reset_mid();
    int lat, elat, seen;
    logic [60:0] er;
    @(negedge clk);
    op_a = 32'h40400000;
    op_b = 32'h40000000;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({in_ready, out_valid, res} !== 63'd0) begin
      bad++;
      $display("FAIL rst_mid: got rdy=%b vld=%b res=%h want all 0",
               in_ready, out_valid, res);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL rst_partial: got %0d valid cycles want 0", seen);
    end
    model(32'h7F7FFFFF, 32'hFF7FFFFF, er, elat);
    do_op(32'h7F7FFFFF, 32'hFF7FFFFF, lat);
    total++;
    if (lat !== elat || res !== er) begin
      bad++;
      $display("FAIL rst_after: got lat=%0d res=%h want lat=%0d res=%h",
               lat, res, elat, er);
    end
    retire();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
